// File: rtl/conv_mem_pkg.sv
// conv_mem_pkg: bank select codes, bank depths, sequencer states and depth lookup
package conv_mem_pkg;
  localparam logic [2:0] CSEL_L0K0 = 3'd1;
  localparam logic [2:0] CSEL_L0K1 = 3'd2;
  localparam logic [2:0] CSEL_L1K0 = 3'd3;
  localparam logic [2:0] CSEL_L1K1 = 3'd4;
  localparam logic [2:0] CSEL_L2   = 3'd5;
  localparam int L0_DEPTH = 4096;
  localparam int L1_DEPTH = 1024;
  localparam int L2_DEPTH = 2048;
  typedef enum logic [2:0] {S_LOAD, S_ARM, S_RUN, S_DONE, S_DUMP} state_t;
  // Zero marks a select code that names no bank
  function automatic int bank_depth(input logic [2:0] sel);
    return (sel == CSEL_L0K0 || sel == CSEL_L0K1) ? L0_DEPTH :
           (sel == CSEL_L1K0 || sel == CSEL_L1K1) ? L1_DEPTH :
           (sel == CSEL_L2) ? L2_DEPTH : 0;
  endfunction
endpackage

// File: rtl/conv_mem_host_if.sv
// conv_mem_host_if: load stream, accelerator memory bus and dump port of the CONV memory host
interface conv_mem_host_if #(parameter int DW = 20, parameter int IMG_AW = 12);
  logic img_valid;
  logic [DW-1:0] img_data;
  logic img_ready;
  logic ready;
  logic busy;
  logic [IMG_AW-1:0] iaddr;
  logic [DW-1:0] idata;
  logic cwr;
  logic [11:0] caddr_wr;
  logic [DW-1:0] cdata_wr;
  logic crd;
  logic [11:0] caddr_rd;
  logic [DW-1:0] cdata_rd;
  logic [2:0] csel;
  logic done;
  logic load_start;
  logic dump_req;
  logic [2:0] dump_sel;
  logic dump_valid;
  logic [11:0] dump_addr;
  logic [DW-1:0] dump_data;
  logic dump_last;
  modport master (
    output img_valid, img_data, busy, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel,
           load_start, dump_req, dump_sel,
    input  img_ready, ready, idata, cdata_rd, done, dump_valid, dump_addr, dump_data, dump_last
  );
  modport slave (
    input  img_valid, img_data, busy, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel,
           load_start, dump_req, dump_sel,
    output img_ready, ready, idata, cdata_rd, done, dump_valid, dump_addr, dump_data, dump_last
  );
endinterface

// File: rtl/conv_mem_bank.sv
// conv_mem_bank: unreset word array with one synchronous write port and NR asynchronous read ports
module conv_mem_bank #(
  parameter int DEPTH = 4096,
  parameter int DW = 20,
  parameter int NR = 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [NR-1:0][AW-1:0] raddr,
  output logic [NR-1:0][DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  // Write lands at the edge, so a same-cycle read still returns the old word
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  for (genvar r = 0; r < NR; r++) begin : g_rd
    assign rdata[r] = mem[raddr[r]];
  end
endmodule

// File: rtl/conv_mem_host.sv
// conv_mem_host: synthesizable memory-side responder for the CONV accelerator
module conv_mem_host
  import conv_mem_pkg::*;
#(
  parameter int DW = 20,
  parameter int IMG_AW = 12,
  parameter int L1_AW = 10,
  parameter int L2_AW = 11
) (
  input logic clk,
  input logic reset_n,
  conv_mem_host_if.slave bus
);
  state_t state;
  logic [IMG_AW-1:0] cnt;
  logic [2:0] dsel;
  logic [2:0] cidx;
  logic [2:0] didx;
  logic [11:0] dump_end;
  logic [1:0][DW-1:0] rd [5];
  function automatic int sel_aw(input logic [2:0] sel);
    return sel <= CSEL_L0K1 ? IMG_AW : sel <= CSEL_L1K1 ? L1_AW : L2_AW;
  endfunction
  conv_mem_bank #(.DEPTH(1 << IMG_AW), .DW(DW)) u_img (
    .clk(clk), .we(state == S_LOAD && bus.img_valid), .waddr(cnt), .wdata(bus.img_data),
    .raddr(bus.iaddr), .rdata(bus.idata)
  );
  // Port 0 serves the accelerator, port 1 the dump stream
  for (genvar k = 0; k < 5; k++) begin : g_bank
    localparam int AW = sel_aw(3'(k + 1));
    conv_mem_bank #(.DEPTH(1 << AW), .DW(DW), .NR(2)) u_bank (
      .clk(clk), .we(bus.cwr && state == S_RUN && bus.csel == 3'(k + 1)),
      .waddr(bus.caddr_wr[AW-1:0]), .wdata(bus.cdata_wr),
      .raddr({bus.dump_addr[AW-1:0], bus.caddr_rd[AW-1:0]}), .rdata(rd[k])
    );
  end
  assign cidx = bus.csel - 3'd1;
  assign didx = dsel - 3'd1;
  assign dump_end = 12'((1 << sel_aw(dsel)) - 1);
  assign bus.cdata_rd = (bus.crd && bank_depth(bus.csel) != 0) ? rd[cidx][0] : '0;
  assign bus.dump_data = bus.dump_valid ? rd[didx][1] : '0;
  // Sequencer: load image, arm, run, report done and dump banks, all outputs registered
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= S_LOAD;
      cnt <= '0;
      dsel <= '0;
      bus.img_ready <= 1'b1;
      bus.ready <= 1'b0;
      bus.done <= 1'b0;
      bus.dump_valid <= 1'b0;
      bus.dump_last <= 1'b0;
      bus.dump_addr <= '0;
    end else
      case (state)
        S_LOAD: if (bus.img_valid) begin
          cnt <= cnt + 1'b1;
          if (&cnt) begin
            state <= S_ARM;
            bus.img_ready <= 1'b0;
            bus.ready <= 1'b1;
          end
        end
        S_ARM: if (bus.busy) begin
          state <= S_RUN;
          bus.ready <= 1'b0;
        end
        S_RUN: if (!bus.busy) begin
          state <= S_DONE;
          bus.done <= 1'b1;
        end
        S_DONE:
          if (bus.load_start) begin
            state <= S_LOAD;
            bus.done <= 1'b0;
            bus.img_ready <= 1'b1;
          end else if (bus.dump_req && bank_depth(bus.dump_sel) != 0) begin
            state <= S_DUMP;
            bus.done <= 1'b0;
            bus.dump_valid <= 1'b1;
            bus.dump_addr <= '0;
            dsel <= bus.dump_sel;
          end
        S_DUMP:
          if (bus.dump_last) begin
            state <= S_DONE;
            bus.done <= 1'b1;
            bus.dump_valid <= 1'b0;
            bus.dump_last <= 1'b0;
            bus.dump_addr <= '0;
          end else begin
            bus.dump_addr <= bus.dump_addr + 12'd1;
            bus.dump_last <= bus.dump_addr + 12'd1 == dump_end;
          end
        default: state <= S_LOAD;
      endcase
endmodule

// File: tb/tb_conv_mem_host.sv
// tb_conv_mem_host: vector table, directed sequences and random traffic against a memory model
module tb_conv_mem_host;
  localparam int DW = 20;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  conv_mem_host_if #(.DW(DW), .IMG_AW(12)) bus ();
  conv_mem_host dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));
  int tests = 0;
  int fails = 0;
  logic [DW-1:0] img_m [4096];
  logic [DW-1:0] lay_m [5][4096];
  typedef struct {
    logic cwr;
    logic crd;
    logic [2:0] csel;
    logic [11:0] aw;
    logic [DW-1:0] dw;
    logic [11:0] ar;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t tbl [10];
  function automatic int depth(input int sel);
    return sel inside {1, 2} ? 4096 : sel inside {3, 4} ? 1024 : sel == 5 ? 2048 : 0;
  endfunction
  function automatic logic [DW-1:0] rd_m(input int sel, input int addr);
    if (depth(sel) == 0) return '0;
    return lay_m[sel-1][addr % depth(sel)];
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    bus.img_valid = 0; bus.img_data = '0; bus.iaddr = '0;
    bus.cwr = 0; bus.caddr_wr = '0; bus.cdata_wr = '0;
    bus.crd = 0; bus.caddr_rd = '0; bus.csel = '0;
    bus.load_start = 0; bus.dump_req = 0; bus.dump_sel = '0;
  endtask
  task automatic wr(input int sel, input int addr, input logic [DW-1:0] data);
    bus.cwr = 1; bus.csel = 3'(sel); bus.caddr_wr = 12'(addr); bus.cdata_wr = data;
    step();
    if (depth(sel) != 0) lay_m[sel-1][addr % depth(sel)] = data;
    bus.cwr = 0;
  endtask
  task automatic load_image(input bit ramp);
    int i = 0;
    while (i < 4096) begin
      bus.img_valid = ($urandom_range(0, 7) != 0);
      bus.img_data = ramp ? DW'(i) : DW'($urandom);
      if (bus.img_valid && i == 4095) chk("ready before last beat", {bus.ready, bus.img_ready}, 2'b01);
      step();
      if (bus.img_valid) begin
        img_m[i] = bus.img_data;
        i++;
      end
    end
    bus.img_valid = 0;
    chk("ready after last beat", {bus.ready, bus.img_ready}, 2'b10);
  endtask
  task automatic img_reads();
    for (int n = 0; n < 16; n++) begin
      bus.iaddr = 12'($urandom);
      #1 chk($sformatf("idata @%0h", bus.iaddr), bus.idata, img_m[bus.iaddr]);
    end
  endtask
  task automatic dump_bank(input int sel);
    int d = depth(sel);
    bus.dump_req = 1; bus.dump_sel = 3'(sel);
    step();
    bus.dump_req = 0; bus.dump_sel = '0;
    for (int i = 0; i < d; i++) begin
      chk($sformatf("dump sel%0d beat %0d", sel, i), {bus.dump_valid, bus.dump_last, bus.dump_addr, bus.dump_data},
          {1'b1, 1'(i == d - 1), 12'(i), lay_m[sel-1][i]});
      step();
    end
    chk("after dump", {bus.dump_valid, bus.dump_last, bus.done}, 3'b001);
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{1, 0, 3, 12'h7FF, 20'h12345, 12'h000, 20'h00000};
    tbl[1] = '{0, 1, 3, 12'h000, 20'h00000, 12'h3FF, 20'h12345};
    tbl[2] = '{1, 1, 6, 12'h3FF, 20'hFFFFF, 12'h3FF, 20'h00000};
    tbl[3] = '{0, 1, 3, 12'h000, 20'h00000, 12'h3FF, 20'h12345};
    tbl[4] = '{1, 0, 1, 12'h010, 20'h00001, 12'h000, 20'h00000};
    tbl[5] = '{1, 1, 1, 12'h010, 20'h0ABCD, 12'h010, 20'h00001};
    tbl[6] = '{0, 1, 1, 12'h000, 20'h00000, 12'h010, 20'h0ABCD};
    tbl[7] = '{1, 0, 5, 12'h800, 20'h55555, 12'h000, 20'h00000};
    tbl[8] = '{0, 1, 5, 12'h000, 20'h00000, 12'h000, 20'h55555};
    tbl[9] = '{0, 0, 5, 12'h000, 20'h00000, 12'h000, 20'h00000};
    clr();
    bus.busy = 0;
    repeat (3) step();
    chk("reset outputs", {bus.img_ready, bus.ready, bus.done, bus.dump_valid, bus.dump_last, bus.dump_addr}, {5'b10000, 12'h000});
    reset_n = 1;
    load_image(1);
    bus.iaddr = 12'h0A5;
    #1 chk("idata 0A5", bus.idata, 20'h000A5);
    bus.img_valid = 1; bus.img_data = '1;
    repeat (10) step();
    chk("ready held in ARM", {bus.ready, bus.img_ready, bus.done}, 3'b100);
    bus.img_valid = 0; bus.busy = 1;
    step();
    chk("ready drops in RUN", bus.ready, 1'b0);
    bus.iaddr = 12'h000;
    #1 chk("ARM beat ignored", bus.idata, 20'h00000);
    img_reads();
    for (int s = 1; s <= 5; s++)
      for (int a = 0; a < depth(s); a++) wr(s, a, DW'($urandom));
    for (int v = 0; v < 10; v++) begin
      bus.cwr = tbl[v].cwr; bus.crd = tbl[v].crd; bus.csel = tbl[v].csel;
      bus.caddr_wr = tbl[v].aw; bus.cdata_wr = tbl[v].dw; bus.caddr_rd = tbl[v].ar;
      #1 chk($sformatf("vector %0d cdata_rd", v), bus.cdata_rd, tbl[v].exp);
      step();
      if (tbl[v].cwr && depth(tbl[v].csel) != 0) lay_m[tbl[v].csel-1][tbl[v].aw % depth(tbl[v].csel)] = tbl[v].dw;
    end
    for (int n = 0; n < 300; n++) begin
      bus.cwr = 1'($urandom); bus.crd = 1'($urandom); bus.csel = 3'($urandom);
      bus.caddr_wr = 12'($urandom);
      bus.caddr_rd = $urandom_range(0, 1) ? bus.caddr_wr : 12'($urandom);
      bus.cdata_wr = DW'($urandom);
      bus.dump_req = 1'($urandom); bus.dump_sel = 3'($urandom_range(1, 5));
      #1 chk("random cdata_rd", bus.cdata_rd, bus.crd ? rd_m(bus.csel, bus.caddr_rd) : '0);
      step();
      if (bus.cwr && depth(bus.csel) != 0) lay_m[bus.csel-1][bus.caddr_wr % depth(bus.csel)] = bus.cdata_wr;
    end
    clr();
    chk("still running", {bus.done, bus.dump_valid}, 2'b00);
    bus.busy = 0;
    step();
    chk("done after busy falls", {bus.done, bus.ready}, 2'b10);
    bus.cwr = 1; bus.csel = 5; bus.caddr_wr = 12'h000; bus.cdata_wr = 20'hAAAAA;
    step();
    clr();
    bus.dump_req = 1; bus.dump_sel = 7;
    step();
    chk("invalid dump_sel ignored", {bus.dump_valid, bus.done}, 2'b01);
    clr();
    dump_bank(5);
    bus.load_start = 1; bus.dump_req = 1; bus.dump_sel = 5;
    step();
    chk("load_start wins", {bus.img_ready, bus.dump_valid, bus.done}, 3'b100);
    clr();
    load_image(0);
    img_reads();
    bus.busy = 1;
    step();
    bus.busy = 0;
    step();
    chk("second run done", bus.done, 1'b1);
    dump_bank(3);
    bus.dump_req = 1; bus.dump_sel = 5;
    step();
    clr();
    repeat (100) step();
    chk("mid dump", {bus.dump_valid, bus.dump_addr}, {1'b1, 12'd100});
    reset_n = 0;
    #1 chk("async reset mid dump", {bus.dump_valid, bus.img_ready, bus.done, bus.ready}, 4'b0100);
    repeat (2) step();
    reset_n = 1;
    load_image(0);
    img_reads();
    bus.busy = 1;
    step();
    bus.crd = 1; bus.csel = 5; bus.caddr_rd = 12'h000;
    #1 chk("L2 @0 kept", bus.cdata_rd, rd_m(5, 0));
    for (int n = 0; n < 20; n++) begin
      bus.caddr_rd = 12'($urandom);
      #1 chk($sformatf("L2 kept @%0h", bus.caddr_rd), bus.cdata_rd, rd_m(5, bus.caddr_rd));
    end
    clr();
    bus.busy = 0;
    step();
    chk("third run done", bus.done, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
